axis_radix2_divider: RTL and testbench

Iterative radix-2 restoring divider that is the responder side of the execute-stage divide request interface. It accepts a dividend and a divisor on two independent AXI-Stream slave channels and returns `{remainder, quotient}` on one AXI-Stream master channel, in non-blocking mode. It drops in for either vendor divider instance, signed or unsigned, and needs no IP core. Results follow RISC-V M-extension semantics, including divide-by-zero and signed overflow.

---
 rtl/axis_radix2_divider.sv | 161 ++++++++++++++++
 tb/tb_axis_radix2_divider.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_radix2_divider.sv
// Iterative radix-2 restoring divider with AXI-Stream operand/result channels, RISC-V M semantics.
// Define DIV_EARLY_OUT_EN to skip the iterations for divide-by-zero, signed overflow and divide-by-one.
module axis_radix2_divider #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 aclken,
  input  logic                 s_axis_dividend_tvalid,
  output logic                 s_axis_dividend_tready,
  input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
  input  logic                 s_axis_divisor_tvalid,
  output logic                 s_axis_divisor_tready,
  input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
  output logic                 m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);
  // state | meaning
  // IDLE  | collecting dividend and divisor
  // PREP  | take magnitudes, record signs and special cases
  // ITER  | one quotient bit per cycle, WIDTH cycles
  // FIX   | sign correction and special-case override, register result
  // DONE  | result valid for one enabled cycle
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2:0]       state;
  logic             got_a, got_b;
  logic [WIDTH-1:0] a_raw, b_raw, b_mag, rem, quo;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, div_zero, ovf;
`ifdef DIV_EARLY_OUT_EN
  logic             div_one;
`endif

  logic             fire_a, fire_b, a_neg, b_neg, a_min, b_ones, b_one, b_zero;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, q_fix, r_fix;
  logic [WIDTH:0]   shifted, diff;

  assign s_axis_dividend_tready = aclken && (state == S_IDLE) && !got_a;
  assign s_axis_divisor_tready  = aclken && (state == S_IDLE) && !got_b;
  assign fire_a = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign fire_b = s_axis_divisor_tvalid && s_axis_divisor_tready;
  assign m_axis_dout_tvalid = (state == S_DONE);

  assign a_neg   = SIGNED && a_raw[WIDTH-1];
  assign b_neg   = SIGNED && b_raw[WIDTH-1];
  assign a_mag_c = a_neg ? -a_raw : a_raw;
  assign b_mag_c = b_neg ? -b_raw : b_raw;
  assign a_min   = (a_raw == {1'b1, {(WIDTH-1){1'b0}}});
  assign b_ones  = &b_raw;
  assign b_one   = (b_raw == {{(WIDTH-1){1'b0}}, 1'b1});
  assign b_zero  = (b_raw == '0);

  // Partial remainder is always below the divisor, so WIDTH+1 bits hold the trial difference.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_mag};

  always_comb begin
    q_fix = neg_q ? -quo : quo;
    r_fix = neg_r ? -rem : rem;
    if (div_zero) begin
      q_fix = '1;
      r_fix = a_raw;
    end else if (ovf) begin
      q_fix = {1'b1, {(WIDTH-1){1'b0}}};
      r_fix = '0;
    end
`ifdef DIV_EARLY_OUT_EN
    else if (div_one) begin
      q_fix = a_raw;
      r_fix = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      got_a             <= 1'b0;
      got_b             <= 1'b0;
      a_raw             <= '0;
      b_raw             <= '0;
      b_mag             <= '0;
      rem               <= '0;
      quo               <= '0;
      cnt               <= '0;
      neg_q             <= 1'b0;
      neg_r             <= 1'b0;
      div_zero          <= 1'b0;
      ovf               <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
      div_one           <= 1'b0;
`endif
      m_axis_dout_tdata <= '0;
    end else if (aclken) begin
      case (state)
        S_IDLE: begin
          if (fire_a) begin
            a_raw <= s_axis_dividend_tdata;
            got_a <= 1'b1;
          end
          if (fire_b) begin
            b_raw <= s_axis_divisor_tdata;
            got_b <= 1'b1;
          end
          if ((got_a || fire_a) && (got_b || fire_b))
            state <= S_PREP;
        end
        S_PREP: begin
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
          quo      <= a_mag_c;
          b_mag    <= b_mag_c;
          rem      <= '0;
          cnt      <= CW'(WIDTH-1);
          div_zero <= b_zero;
          ovf      <= SIGNED && a_min && b_ones;
`ifdef DIV_EARLY_OUT_EN
          div_one  <= b_one;
          if (b_zero || b_one || (SIGNED && a_min && b_ones))
            state <= S_FIX;
          else
            state <= S_ITER;
`else
          state    <= S_ITER;
`endif
        end
        S_ITER: begin
          rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          if (cnt == '0)
            state <= S_FIX;
          else
            cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          m_axis_dout_tdata <= {r_fix, q_fix};
          state             <= S_DONE;
        end
        S_DONE: begin
          got_a <= 1'b0;
          got_b <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef DIV_EARLY_OUT_EN
  logic unused_b_one;
  assign unused_b_one = b_one;
`endif

endmodule

// File: tb/tb_axis_radix2_divider.sv
// Bench for axis_radix2_divider: unsigned and signed instances share stimulus, checked against an arithmetic model.
module tb_axis_radix2_divider;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        aclken = 1'b1;
  logic        dvd_valid = 1'b0, dvs_valid = 1'b0;
  logic [31:0] dvd_data = '0, dvs_data = '0;
  logic        rdy_a [2];
  logic        rdy_b [2];
  logic        vld   [2];
  logic [63:0] dout  [2];

  always #5 clk = ~clk;

  axis_radix2_divider #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .aclken(aclken),
    .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(rdy_a[0]), .s_axis_dividend_tdata(dvd_data),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(rdy_b[0]), .s_axis_divisor_tdata(dvs_data),
    .m_axis_dout_tvalid(vld[0]), .m_axis_dout_tdata(dout[0]));

  axis_radix2_divider #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .aclken(aclken),
    .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(rdy_a[1]), .s_axis_dividend_tdata(dvd_data),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(rdy_b[1]), .s_axis_divisor_tdata(dvs_data),
    .m_axis_dout_tvalid(vld[1]), .m_axis_dout_tdata(dout[1]));

  int checks = 0, errors = 0;

  // Model state per instance (0 = unsigned, 1 = signed)
  bit          got_a [2], got_b [2], busy [2], pend [2], hold [2];
  logic [31:0] va [2], vb [2];
  logic [63:0] exp_data [2];
  int          exp_edge [2], cap_raw [2], raw_lat [2], pulse_cnt [2], last_cap [2], prev_cap [2];
  int          edges = 0, raw = 0;
  bit          fire_a0 = 0, fire_b0 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input bit sgn);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'd0 || b == 32'd1 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 3;
`endif
    return (a === 32'hx || b === 32'hx || sgn === 1'bx) ? 0 : 35;
  endfunction

  always @(negedge clk) begin : model
    bit ra, rb, fa, fb;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        got_a[k] = 0; got_b[k] = 0; busy[k] = 0; pend[k] = 0; hold[k] = 0;
      end
      fire_a0 = 0;
      fire_b0 = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        ra = aclken && !busy[k] && !got_a[k];
        rb = aclken && !busy[k] && !got_b[k];
        chk($sformatf("dividend_tready[%0d]", k), 64'(rdy_a[k]), 64'(ra));
        chk($sformatf("divisor_tready[%0d]", k), 64'(rdy_b[k]), 64'(rb));
        if (vld[k]) begin
          if (!hold[k]) begin
            pulse_cnt[k]++;
            checks++;
            if (!pend[k]) begin
              errors++;
              $display("FAIL spurious_tvalid[%0d]: tvalid 1 expected 0", k);
            end else begin
              chk($sformatf("dout[%0d]", k), dout[k], exp_data[k]);
              chk($sformatf("latency_edge[%0d]", k), 64'(edges), 64'(exp_edge[k]));
              raw_lat[k] = raw - cap_raw[k] + 1;
              pend[k] = 0;
            end
          end
          if (aclken) busy[k] = 0;
          hold[k] = !aclken;
        end else begin
          hold[k] = 0;
          if (pend[k] && edges > exp_edge[k]) begin
            checks++;
            errors++;
            $display("FAIL missing_tvalid[%0d]: no pulse by edge %0d expected at %0d", k, edges, exp_edge[k]);
            pend[k] = 0;
            busy[k] = 0;
          end
        end
        fa = dvd_valid && ra;
        fb = dvs_valid && rb;
        if (fa) begin got_a[k] = 1; va[k] = dvd_data; end
        if (fb) begin got_b[k] = 1; vb[k] = dvs_data; end
        if (got_a[k] && got_b[k]) begin
          exp_data[k] = ref_div(va[k], vb[k], k == 1);
          exp_edge[k] = edges + ref_lat(va[k], vb[k], k == 1);
          cap_raw[k]  = raw + 1;
          prev_cap[k] = last_cap[k];
          last_cap[k] = edges + 1;
          pend[k] = 1;
          busy[k] = 1;
          got_a[k] = 0;
          got_b[k] = 0;
        end
        if (k == 0) begin fire_a0 = fa; fire_b0 = fb; end
      end
      if (aclken) edges++;
      raw++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [31:0] a, input int dly);
    bit f = 0;
    repeat (dly) tick();
    dvd_valid = 1; dvd_data = a;
    for (int i = 0; i < 200 && !f; i++) begin
      @(posedge clk); f = fire_a0; #1;
    end
    checks++;
    if (!f) begin errors++; $display("FAIL accept_dividend: accepted 0 expected 1"); end
    dvd_valid = 0;
  endtask

  task automatic send_b(input logic [31:0] b, input int dly);
    bit f = 0;
    repeat (dly) tick();
    dvs_valid = 1; dvs_data = b;
    for (int i = 0; i < 200 && !f; i++) begin
      @(posedge clk); f = fire_b0; #1;
    end
    checks++;
    if (!f) begin errors++; $display("FAIL accept_divisor: accepted 0 expected 1"); end
    dvs_valid = 0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    fork
      send_a(a, 0);
      send_b(b, 0);
    join
  endtask

  task automatic wait_idle;
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      done = !busy[0] && !busy[1] && !got_a[0] && !got_b[0] && !got_a[1] && !got_b[1];
    end
    checks++;
    if (!done) begin errors++; $display("FAIL wait_idle: busy 1 expected 0"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_tvalid[%0d]", k), 64'(vld[k]), 64'd0);
      chk($sformatf("reset_tdata[%0d]", k), dout[k], 64'd0);
      chk($sformatf("reset_rdy_a[%0d]", k), 64'(rdy_a[k]), 64'd1);
      chk($sformatf("reset_rdy_b[%0d]", k), 64'(rdy_b[k]), 64'd1);
    end
    tick();
    reset = 0;
    tick();

    chk("ref_100_7_u",  ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    chk("ref_m7_2_s",   ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("ref_7_m2_s",   ref_div(32'd7, 32'hFFFF_FFFE, 1'b1), {32'd1, 32'hFFFF_FFFD});
    chk("ref_div0_u",   ref_div(32'h8000_0005, 32'd0, 1'b0), {32'h8000_0005, 32'hFFFF_FFFF});
    chk("ref_div0_s",   ref_div(32'h8000_0005, 32'd0, 1'b1), {32'h8000_0005, 32'hFFFF_FFFF});
    chk("ref_ovf_s",    ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h0, 32'h8000_0000});
    chk("ref_lat_full", 64'(ref_lat(32'd100, 32'd7, 1'b0)), 64'd35);

    run_op(32'd100, 32'd7);
    wait_idle();
    chk("lit_100_7_u", dout[0], {32'd2, 32'd14});
    run_op(32'hFFFF_FFF9, 32'd2);
    wait_idle();
    chk("lit_m7_2_s", dout[1], {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(32'd7, 32'hFFFF_FFFE);
    wait_idle();
    run_op(32'h8000_0005, 32'd0);
    wait_idle();
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("lit_ovf_s", dout[1], {32'h0, 32'h8000_0000});
    run_op(32'h1234_5678, 32'd1);
    wait_idle();

    // dividend first, divisor five cycles later, clock enable dropped inside the iterations
    fork
      send_a(32'd1000, 0);
      send_b(32'd3, 5);
      begin
        repeat (15) tick();
        aclken = 0;
        repeat (4) tick();
        aclken = 1;
      end
    join
    wait_idle();
    chk("raw_latency_gap_u", 64'(raw_lat[0]), 64'd39);
    chk("raw_latency_gap_s", 64'(raw_lat[1]), 64'd39);

    // abort mid-iteration
    run_op(32'd200, 32'd7);
    repeat (12) tick();
    pc = pulse_cnt[0] + pulse_cnt[1];
    reset = 1;
    tick();
    reset = 0;
    repeat (45) tick();
    chk("no_tvalid_after_reset", 64'(pulse_cnt[0] + pulse_cnt[1]), 64'(pc));
    run_op(32'd9, 32'd3);
    wait_idle();
    chk("lit_9_3_u", dout[0], {32'd0, 32'd3});
    chk("lit_9_3_s", dout[1], {32'd0, 32'd3});

    // second operation presented while the first is still running
    run_op(32'd50, 32'd6);
    run_op(32'd77, 32'd10);
    wait_idle();
    chk("initiation_interval", 64'(last_cap[0] - prev_cap[0]), 64'd36);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
